// File: rtl/fixed_to_float.sv
// Converts a 24-bit signed fixed-point value (FRAC_BITS fractional bits) into an
// IEEE-754 single-precision word by shifting the magnitude left one bit per
// cycle until its leading one reaches bit 23. The result is always exact.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// NORM  | shifting mag left until bit 23 is set, decrementing exp each shift
// OUT   | floatingPoint valid, held until out_ready
module fixed_to_float #(
  parameter int FRAC_BITS = 22
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] fixedPoint,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] floatingPoint,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, NORM, OUT} state_t;

  // Exponent when the input's bit 23 is the leading one; each NORM shift lowers it by one.
  localparam logic [8:0] EXP_INIT = 9'(127 + 23 - FRAC_BITS);

  state_t      state;
  logic [23:0] magReg;
  logic [8:0]  expReg;
  logic        signReg;
  logic [23:0] absIn;

  // Magnitude of the input; -2^23 negates to 24'h800000, which is still correct as unsigned.
  always_comb begin
    absIn = fixedPoint;
    if (fixedPoint[23]) absIn = ~fixedPoint + 24'd1;
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Accept, normalise and hold the result until it is taken downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      out_valid     <= 1'b0;
      floatingPoint <= 32'h0;
      magReg        <= 24'h0;
      expReg        <= 9'h0;
      signReg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            signReg <= fixedPoint[23];
            magReg  <= absIn;
            expReg  <= EXP_INIT;
            if (absIn == 24'h0) begin
              // Zero skips normalisation and is always emitted as +0.
              floatingPoint <= 32'h0;
              out_valid     <= 1'b1;
              state         <= OUT;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (magReg[23]) begin
            floatingPoint <= {signReg, 8'(expReg), magReg[22:0]};
            out_valid     <= 1'b1;
            state         <= OUT;
          end else begin
            magReg <= {magReg[22:0], 1'b0};
            expReg <= expReg - 9'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_float.sv
// Directed and randomized checks of fixed_to_float against a reference model
// built from real arithmetic ($realtobits) and an independent float-to-fixed inverse.
module tb_fixed_to_float;
  localparam int FRAC = 22;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] fixedPoint;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] floatingPoint;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fixed_to_float #(.FRAC_BITS(FRAC)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .fixedPoint(fixedPoint), .out_valid(out_valid), .out_ready(out_ready),
    .floatingPoint(floatingPoint), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: value = signed(v) / 2^FRAC, encoded via the double-precision bit pattern.
  function automatic logic [31:0] modelFloat(input logic [23:0] v);
    int          sv;
    real         r;
    logic [63:0] b;
    int          e;
    sv = int'($signed(v));
    if (sv == 0) return 32'h0;
    r = real'(sv) / real'(1 << FRAC);
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], 8'(e), b[51:29]};
  endfunction

  // Reference latency: accept edge + one edge per leading zero + the emitting edge.
  function automatic int modelLatency(input logic [23:0] v);
    int m;
    int p;
    m = int'($signed(v));
    if (m < 0) m = -m;
    if (m == 0) return 1;
    p = 0;
    while (m > 1) begin
      m = m >> 1;
      p++;
    end
    return (23 - p) + 2;
  endfunction

  // Inverse conversion (float back to fixed) for round-trip checking.
  function automatic logic [23:0] toFixed(input logic [31:0] f);
    longint m;
    int     e;
    if (f[30:0] == 31'h0) return 24'h0;
    e = int'(f[30:23]);
    m = longint'({1'b1, f[22:0]});
    m = m >>> (150 - FRAC - e);
    if (f[31]) m = -m;
    return m[23:0];
  endfunction

  // Present one input, wait (bounded) for out_valid; leaves the result held.
  task automatic convert(input logic [23:0] v, output logic [31:0] res, output int edges);
    fixedPoint = v;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    fixedPoint = 24'($urandom);
    edges = 1;
    while (out_valid !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    if (out_valid !== 1'b1) check("timeout_out_valid", {31'h0, out_valid}, 32'h1);
    res = floatingPoint;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    logic [23:0] v;
    int          edges;
    int          seen;

    reset_n    = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    fixedPoint = 24'h0;
    #23;
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_float", floatingPoint, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", {31'h0, in_ready}, 32'h1);

    // Reset in the middle of normalisation aborts the conversion.
    fixedPoint = 24'h000001;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("midnorm_busy", {31'h0, busy}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_out_valid", {31'h0, out_valid}, 32'h0);
    check("abort_float", floatingPoint, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready", {31'h0, in_ready}, 32'h1);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("abort_no_output", 32'(seen), 32'h0);

    // Directed values with spec-given results and latencies.
    convert(24'h000000, res, edges);
    check("zero_val", res, 32'h00000000);
    check("zero_lat", 32'(edges), 32'd1);
    handshake();
    convert(24'h400000, res, edges);
    check("one_val", res, 32'h3F800000);
    check("one_lat", 32'(edges), 32'd3);
    handshake();
    convert(24'hC00000, res, edges);
    check("negone_val", res, 32'hBF800000);
    handshake();
    convert(24'h300000, res, edges);
    check("p75_val", res, 32'h3F400000);
    check("p75_lat", 32'(edges), 32'd4);
    handshake();
    convert(24'h800000, res, edges);
    check("negtwo_val", res, 32'hC0000000);
    check("negtwo_lat", 32'(edges), 32'd2);
    handshake();
    convert(24'h000001, res, edges);
    check("lsb_val", res, 32'h34800000);
    check("lsb_lat", 32'(edges), 32'd25);
    handshake();
    convert(24'hFFFFFF, res, edges);
    check("neglsb_val", res, 32'hB4800000);
    handshake();

    // Backpressure: result holds, extra input ignored, no accept on the handshake cycle.
    convert(24'h123456, res, edges);
    held = res;
    fixedPoint = 24'h400000;
    in_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_float_stable", floatingPoint, held);
      check("bp_in_ready", {31'h0, in_ready}, 32'h0);
      check("bp_out_valid", {31'h0, out_valid}, 32'h1);
    end
    check("bp_value", held, modelFloat(24'h123456));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", {31'h0, out_valid}, 32'h0);
    check("bp_release_idle", {31'h0, busy}, 32'h0);
    check("bp_release_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_accepted", {31'h0, busy}, 32'h1);
    edges = 1;
    while (out_valid !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("bp_next_val", floatingPoint, 32'h3F800000);
    handshake();

    // Randomized values: model value, latency and round trip.
    for (int n = 0; n < 1000; n++) begin
      v = 24'($urandom);
      convert(v, res, edges);
      check("rand_val", res, modelFloat(v));
      check("rand_lat", 32'(edges), 32'(modelLatency(v)));
      check("rand_roundtrip", {8'h0, toFixed(res)}, {8'h0, v});
      handshake();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end
endmodule
